// File: rtl/keys_debouncer_pkg.sv
// Shared constants for the keys debouncer: board width, default timing, pin polarity.
package keys_debouncer_pkg;

  localparam int KEYS_WIDTH                = 32;
  localparam int KEYS_TICK_DIV_DEFAULT     = 50000;
  localparam int KEYS_STABLE_TICKS_DEFAULT = 4;
  localparam int KEYS_ACTIVE_LOW           = 1;

  // Width of the per-bit tick counter; must hold values 0..stable_ticks.
  function automatic int keys_cnt_width(input int stable_ticks);
    return (stable_ticks < 1) ? 1 : $clog2(stable_ticks + 1);
  endfunction

  // Width of the shared prescaler counting 0..tick_div-1.
  function automatic int keys_div_width(input int tick_div);
    return (tick_div < 2) ? 1 : $clog2(tick_div);
  endfunction

endpackage

// File: rtl/keys_debouncer_bit.sv
// One key: 2-flop synchroniser, polarity fix, tick-qualified stability counter,
// debounced level, press pulse and software-cleared sticky press flag.
module key_debounce_bit
  import keys_debouncer_pkg::*;
#(
  parameter int STABLE_TICKS = KEYS_STABLE_TICKS_DEFAULT,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic raw_i,
  input  logic clr_i,
  output logic level_o,
  output logic pulse_o,
  output logic sticky_o
);

  localparam int CW = keys_cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          sync1_q, sync2_q;
  logic          s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic          sticky_q, sticky_d;

  // Sync flops reset to the released pin level so the corrected value starts at 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= ACTIVE_LOW;
      sync2_q <= ACTIVE_LOW;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q ^ ACTIVE_LOW;

  // Any agreeing cycle discards progress; a level is accepted on its STABLE_TICKS-th tick.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    if (s == level_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CNT_LAST) begin
        level_d = s;
        cnt_d   = '0;
        pulse_d = s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // Set comes from the visible pulse and overrides a same-cycle clear.
    sticky_d = pulse_q | (sticky_q & ~clr_i);
  end

  // Debounce state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      level_q  <= 1'b0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
    end
  end

  assign level_o  = level_q;
  assign pulse_o  = pulse_q;
  assign sticky_o = sticky_q;

endmodule

// File: rtl/keys_debouncer.sv
// Keys PIO conditioner: shared sample-tick prescaler feeding WIDTH independent
// debounce slices; exports debounced levels, press pulses and sticky flags.
module keys_debouncer
  import keys_debouncer_pkg::*;
#(
  parameter int WIDTH        = KEYS_WIDTH,
  parameter int TICK_DIV     = KEYS_TICK_DIV_DEFAULT,
  parameter int STABLE_TICKS = KEYS_STABLE_TICKS_DEFAULT,
  parameter int ACTIVE_LOW   = KEYS_ACTIVE_LOW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] keys_raw,
  input  logic [WIDTH-1:0] sticky_clr,
  output logic [WIDTH-1:0] keys_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] press_sticky,
  output logic             any_pressed
);

  localparam int PW = keys_div_width(TICK_DIV);
  localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] prescale_q, prescale_d;
  logic          tick;

  assign tick       = (prescale_q == DIV_LAST);
  assign prescale_d = tick ? '0 : prescale_q + PW'(1);

  // Free-running prescaler; tick marks its terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prescale_q <= '0;
    else       prescale_q <= prescale_d;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    key_debounce_bit #(
      .STABLE_TICKS (STABLE_TICKS),
      .ACTIVE_LOW   (ACTIVE_LOW != 0)
    ) u_bit (
      .clk_i    (clk),
      .rst_i    (reset),
      .tick_i   (tick),
      .raw_i    (keys_raw[i]),
      .clr_i    (sticky_clr[i]),
      .level_o  (keys_out[i]),
      .pulse_o  (press_pulse[i]),
      .sticky_o (press_sticky[i])
    );
  end

  assign any_pressed = |keys_out;

endmodule

// File: tb/tb_keys_debouncer.sv
// Scoreboard bench: a driver advances a tick-counting reference model each
// clock and queues the expected outputs; a monitor pops and compares them.
module tb_keys_debouncer;

  localparam int W  = 4;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam logic [W-1:0] AL_MASK = 4'hF;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] keys_raw = 4'hF;
  logic [W-1:0] sticky_clr = 4'h0;
  logic [W-1:0] keys_out, press_pulse, press_sticky;
  logic         any_pressed;

  keys_debouncer #(.WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST), .ACTIVE_LOW(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .keys_raw     (keys_raw),
    .sticky_clr   (sticky_clr),
    .keys_out     (keys_out),
    .press_pulse  (press_pulse),
    .press_sticky (press_sticky),
    .any_pressed  (any_pressed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] k;
    logic [W-1:0] p;
    logic [W-1:0] s;
    logic         a;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: pins reach the debouncer two clocks late; a bit flips once
  // it has disagreed continuously across ST sample ticks (ticks = cycles c with
  // c mod TD == TD-1, c counted from reset release).
  int           m_c;
  int           m_ds[W];
  logic [W-1:0] m_lvl, m_pul, m_stk, m_h1, m_h2, m_pul_prev;
  logic [W-1:0] raw_p, clr_p;
  logic         rst_p;

  function automatic void model_reset();
    m_c = 0;
    for (int i = 0; i < W; i++) m_ds[i] = -1;
    m_lvl = '0; m_pul = '0; m_stk = '0; m_pul_prev = '0;
    m_h1 = AL_MASK; m_h2 = AL_MASK;
  endfunction

  function automatic void model_step(input logic [W-1:0] r, input logic [W-1:0] cl, input logic rs);
    logic [W-1:0] s, nl, np;
    bit tk;
    int nt;
    if (rs) begin
      model_reset();
      return;
    end
    s  = m_h2 ^ AL_MASK;
    tk = ((m_c % TD) == TD - 1);
    nl = m_lvl;
    np = '0;
    for (int i = 0; i < W; i++) begin
      if (s[i] == m_lvl[i]) m_ds[i] = -1;
      else begin
        if (m_ds[i] < 0) m_ds[i] = m_c;
        nt = (m_c + 1) / TD - m_ds[i] / TD;
        if (tk && nt >= ST) begin
          nl[i]   = s[i];
          np[i]   = s[i];
          m_ds[i] = -1;
        end
      end
    end
    m_stk      = m_pul | (m_stk & ~cl);
    m_pul_prev = m_pul;
    m_pul      = np;
    m_lvl      = nl;
    m_h2       = m_h1;
    m_h1       = r;
    m_c++;
  endfunction

  bit auto_clr = 0;

  // One clock: account for the edge just taken, queue its expected outputs, then apply new inputs.
  task automatic drive(input logic [W-1:0] r, input logic [W-1:0] cl, input logic rs);
    exp_t e;
    logic [W-1:0] c2;
    @(posedge clk);
    #1;
    model_step(raw_p, clr_p, rst_p);
    if (rs) model_reset();
    c2 = auto_clr ? (m_pul | m_pul_prev) : cl;
    e.k = m_lvl; e.p = m_pul; e.s = m_stk; e.a = |m_lvl;
    exp_q.push_back(e);
    keys_raw = r; sticky_clr = c2; reset = rs;
    raw_p = r; clr_p = c2; rst_p = rs;
  endtask

  // Monitor: compare every queued expectation mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        checks++;
        if (keys_out !== '0 || press_pulse !== '0 || press_sticky !== '0 || any_pressed !== 1'b0) begin
          errors++;
          $display("FAIL reset state t=%0t: keys=%h pulse=%h sticky=%h any=%b",
                   $time, keys_out, press_pulse, press_sticky, any_pressed);
        end
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (keys_out !== e.k || press_pulse !== e.p || press_sticky !== e.s || any_pressed !== e.a) begin
          errors++;
          $display("FAIL outputs t=%0t: got keys=%h pulse=%h sticky=%h any=%b, want keys=%h pulse=%h sticky=%h any=%b",
                   $time, keys_out, press_pulse, press_sticky, any_pressed, e.k, e.p, e.s, e.a);
        end
      end
    end
  end

  // Watchdog: the whole sequence must finish well before this expires.
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: wait expired after %0d checks", checks);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [W-1:0] r, cl;
    logic         rs;
    model_reset();
    raw_p = 4'hF; clr_p = '0; rst_p = 1'b1;

    // Reset with all keys released, then idle.
    for (int i = 0; i < 4; i++)  drive(4'hF, 4'h0, 1'b1);
    for (int i = 0; i < 20; i++) drive(4'hF, 4'h0, 1'b0);
    // Press key 0 and hold.
    for (int i = 0; i < 24; i++) drive(4'hE, 4'h0, 1'b0);
    // Key 1 bounces every 3 cycles while key 0 stays pressed.
    for (int i = 0; i < 48; i++) drive(((i / 3) % 2 == 0) ? 4'hC : 4'hE, 4'h0, 1'b0);
    // Release everything.
    for (int i = 0; i < 24; i++) drive(4'hF, 4'h0, 1'b0);
    // Press key 1; clear its sticky flag on the pulse cycle and the one after.
    auto_clr = 1;
    for (int i = 0; i < 24; i++) drive(4'hD, 4'h0, 1'b0);
    auto_clr = 0;
    for (int i = 0; i < 20; i++) drive(4'hF, 4'h0, 1'b0);
    // Press key 3, reset after two ticks while still held, then release reset.
    for (int i = 0; i < 10; i++) drive(4'h7, 4'h0, 1'b0);
    for (int i = 0; i < 2; i++)  drive(4'h7, 4'h0, 1'b1);
    for (int i = 0; i < 30; i++) drive(4'h7, 4'h0, 1'b0);
    for (int i = 0; i < 20; i++) drive(4'hF, 4'hF, 1'b0);

    // Randomised: slow presses, bursts of bounce, random clears, rare resets.
    r = 4'hF;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < W; b++) begin
        if (((i / 200) % 3) == 1) begin
          if ($urandom_range(0, 2) == 0) r[b] = ~r[b];
        end else if ($urandom_range(0, 24) == 0) r[b] = ~r[b];
      end
      cl = '0;
      for (int b = 0; b < W; b++) if ($urandom_range(0, 7) == 0) cl[b] = 1'b1;
      rs = ($urandom_range(0, 499) == 0);
      drive(r, cl, rs);
    end
    for (int i = 0; i < 5; i++) drive(4'hF, 4'h0, 1'b0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0 || checks < 3000) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, %0d checks done", exp_q.size(), checks);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
